// File: rtl/du_rx_way0.sv
// du_rx_way0: execute-stage receiver for the way0 decode->execute handshake.
// Small in-order FIFO with a registered ready_o, pipeline flush and a sticky
// packet-ID sequence checker.
module du_rx_way0 #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [4:0]    rdAddr_i,
  input  logic          rdWriteEnable_i,
  input  logic [63:0]   rs1ReadData_i,
  input  logic [63:0]   rs2ReadData_i,
  input  logic [63:0]   imm_i,
  input  logic [6:0]    opCode_i,
  input  logic [2:0]    funct3_i,
  input  logic [6:0]    funct7_i,
  input  logic [5:0]    shamt_i,
  input  logic [1:0]    way0_pID_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [4:0]    rdAddr_o,
  output logic          rdWriteEnable_o,
  output logic [63:0]   rs1ReadData_o,
  output logic [63:0]   rs2ReadData_o,
  output logic [63:0]   imm_o,
  output logic [6:0]    opCode_o,
  output logic [2:0]    funct3_o,
  output logic [6:0]    funct7_o,
  output logic [5:0]    shamt_o,
  output logic [1:0]    way0_pID_o,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output logic          pid_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = 223;

  logic [PW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wdata;
  logic [PW-1:0] rdata;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;
  logic [1:0]    exp_pid_q, exp_pid_d;
  logic          pid_err_q, pid_err_d;

  logic push;
  logic pop;

  assign wdata = {rdAddr_i, rdWriteEnable_i, rs1ReadData_i, rs2ReadData_i, imm_i,
                  opCode_i, funct3_i, funct7_i, shamt_i, way0_pID_i};
  assign rdata = mem_q[rd_ptr_q];

  assign valid_o = (count_q != '0);
  assign ready_o = ready_q;
  assign count_o = count_q;
  assign pid_err_o = pid_err_q;

  assign {rdAddr_o, rdWriteEnable_o, rs1ReadData_o, rs2ReadData_o, imm_o,
          opCode_o, funct3_o, funct7_o, shamt_o, way0_pID_o} = rdata;

  // Handshakes; flush overrides both in the next-state logic below.
  assign push = valid_i && ready_q;
  assign pop  = valid_o && ready_i;

  // Next-state: pointers, occupancy, registered ready and the pID checker.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    exp_pid_d = exp_pid_q;
    pid_err_d = pid_err_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d  = wr_ptr_q + AW'(1);
        exp_pid_d = way0_pID_i + 2'd1;
        if (way0_pID_i != exp_pid_q) pid_err_d = 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
    // Registered so upstream never sees a combinational path from ready_i.
    ready_d = (count_d < CW'(DEPTH));
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ready_q   <= 1'b1;
      exp_pid_q <= 2'd0;
      pid_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      exp_pid_q <= exp_pid_d;
      pid_err_q <= pid_err_d;
    end
  end

  // Payload storage is not reset; an entry is only read once count covers it.
  always_ff @(posedge clk) begin
    if (push && !flush_i) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: tb/tb_du_rx_way0.sv
// tb_du_rx_way0: scoreboard bench for du_rx_way0 (DEPTH=2).
module tb_du_rx_way0;
  typedef logic [222:0] pkt_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [4:0]  rdAddr_i = '0;
  logic        rdWriteEnable_i = 1'b0;
  logic [63:0] rs1ReadData_i = '0;
  logic [63:0] rs2ReadData_i = '0;
  logic [63:0] imm_i = '0;
  logic [6:0]  opCode_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [6:0]  funct7_i = '0;
  logic [5:0]  shamt_i = '0;
  logic [1:0]  way0_pID_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [4:0]  rdAddr_o;
  logic        rdWriteEnable_o;
  logic [63:0] rs1ReadData_o;
  logic [63:0] rs2ReadData_o;
  logic [63:0] imm_o;
  logic [6:0]  opCode_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [5:0]  shamt_o;
  logic [1:0]  way0_pID_o;
  logic        flush_i = 1'b0;
  logic [1:0]  count_o;
  logic        pid_err_o;

  int   errors = 0;
  int   checks = 0;
  bit   streaming = 1'b0;
  pkt_t sb[$];

  du_rx_way0 #(.DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o),
    .rdAddr_i(rdAddr_i), .rdWriteEnable_i(rdWriteEnable_i),
    .rs1ReadData_i(rs1ReadData_i), .rs2ReadData_i(rs2ReadData_i), .imm_i(imm_i),
    .opCode_i(opCode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .shamt_i(shamt_i), .way0_pID_i(way0_pID_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .rdAddr_o(rdAddr_o), .rdWriteEnable_o(rdWriteEnable_o),
    .rs1ReadData_o(rs1ReadData_o), .rs2ReadData_o(rs2ReadData_o), .imm_o(imm_o),
    .opCode_o(opCode_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
    .shamt_o(shamt_o), .way0_pID_o(way0_pID_o),
    .flush_i(flush_i), .count_o(count_o), .pid_err_o(pid_err_o)
  );

  always #5 clk = ~clk;

  function automatic pkt_t mk(input int idx, input logic [1:0] pid,
                              input logic [63:0] rs1, input logic [63:0] imm);
    logic [31:0] i32;
    i32 = idx;
    return {i32[4:0], i32[0], rs1, {32'hC0DE_0000, i32} ^ 64'h5A5A_0000_0000_0000,
            imm, i32[6:0] ^ 7'h33, i32[2:0], i32[6:0] ^ 7'h21, i32[5:0] ^ 6'h15, pid};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input pkt_t p);
    {rdAddr_i, rdWriteEnable_i, rs1ReadData_i, rs2ReadData_i, imm_i,
     opCode_i, funct3_i, funct7_i, shamt_i, way0_pID_i} = p;
  endtask

  // Offer a packet and hold it until accepted (bounded).
  task automatic send(input pkt_t p);
    int n;
    n = 0;
    drive(p);
    valid_i = 1'b1;
    @(negedge clk);
    while (!ready_o && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!ready_o) begin
      errors++;
      $display("FAIL send_timeout: ready_o got 0 expected 1 within 20 cycles");
    end else begin
      sb.push_back(p);
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    flush_i = 1'b0;
    reset_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every head transfer must match the oldest expected packet.
  always @(negedge clk) begin
    if (reset_n && !flush_i && valid_o && ready_i) begin
      pkt_t act;
      act = {rdAddr_o, rdWriteEnable_o, rs1ReadData_o, rs2ReadData_o, imm_o,
             opCode_o, funct3_o, funct7_o, shamt_o, way0_pID_o};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %0h expected no output", act);
      end else begin
        pkt_t exp;
        exp = sb.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL head_data: got %0h expected %0h", act, exp);
        end
      end
    end
    if (reset_n && streaming) chk("stream_count_le1", 64'(count_o <= 2'd1), 64'd1);
  end

  initial begin
    // Reset then idle
    do_reset();
    @(negedge clk);
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_pid_err", pid_err_o, 0);
    @(posedge clk); #1;

    // Streaming: 8 packets back to back with ready_i high
    ready_i = 1'b1;
    streaming = 1'b1;
    for (int i = 0; i < 8; i++) send(mk(i, 2'(i % 4), 64'h10 + 64'(i), 64'(i) * 64'h100));
    idle(3);
    streaming = 1'b0;
    chk("stream_drained", sb.size(), 0);
    chk("stream_pid_err", pid_err_o, 0);

    // Backpressure: A,B accepted, C held
    ready_i = 1'b0;
    send(mk(20, 2'd0, 64'h20, 64'hA));
    send(mk(21, 2'd1, 64'h21, 64'hB));
    drive(mk(22, 2'd2, 64'h22, 64'hC));
    valid_i = 1'b1;
    @(negedge clk);
    chk("bp_ready_low", ready_o, 0);
    chk("bp_count2", count_o, 2);
    chk("bp_valid", valid_o, 1);
    chk("bp_head_A", imm_o, 64'hA);
    idle(1);
    @(negedge clk);
    chk("bp_still_held", ready_o, 0);
    @(posedge clk); #1;
    ready_i = 1'b1;
    @(negedge clk);
    chk("bp_ready_before_pop", ready_o, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_ready_after_pop", ready_o, 1);
    chk("bp_count_after_pop", count_o, 1);
    sb.push_back(mk(22, 2'd2, 64'h22, 64'hC));
    @(posedge clk); #1;
    valid_i = 1'b0;
    idle(3);
    chk("bp_drained", sb.size(), 0);

    // Flush at full with a simultaneous valid
    ready_i = 1'b0;
    send(mk(30, 2'd3, 64'h30, 64'h300));
    send(mk(31, 2'd0, 64'h31, 64'h301));
    @(negedge clk);
    chk("fl_count2", count_o, 2);
    @(posedge clk); #1;
    drive(mk(32, 2'd1, 64'h32, 64'h302));
    valid_i = 1'b1;
    flush_i = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    chk("fl_count0", count_o, 0);
    chk("fl_valid0", valid_o, 0);
    chk("fl_ready1", ready_o, 1);
    @(posedge clk); #1;

    // Flush while a push would otherwise be accepted; pID state untouched
    send(mk(33, 2'd1, 64'h33, 64'h303));
    drive(mk(34, 2'd3, 64'h34, 64'h304));
    valid_i = 1'b1;
    flush_i = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    chk("fl2_count0", count_o, 0);
    chk("fl2_valid0", valid_o, 0);
    chk("fl2_pid_err", pid_err_o, 0);
    @(posedge clk); #1;
    ready_i = 1'b1;
    idle(3);
    send(mk(35, 2'd2, 64'h35, 64'h305));
    idle(3);
    chk("fl_exp_kept", pid_err_o, 0);
    chk("fl_drained", sb.size(), 0);

    // pID error: 0,1,3,0
    do_reset();
    ready_i = 1'b1;
    send(mk(40, 2'd0, 64'h40, 64'h400));
    send(mk(41, 2'd1, 64'h41, 64'h401));
    @(negedge clk);
    chk("pid_ok_before", pid_err_o, 0);
    @(posedge clk); #1;
    send(mk(42, 2'd3, 64'h42, 64'h402));
    @(negedge clk);
    chk("pid_err_set", pid_err_o, 1);
    @(posedge clk); #1;
    send(mk(43, 2'd0, 64'h43, 64'h403));
    idle(3);
    chk("pid_err_sticky", pid_err_o, 1);
    chk("pid_drained", sb.size(), 0);

    // Wrap: 5 pop/push rounds around count 2, then reset mid-stream
    do_reset();
    @(negedge clk);
    chk("wrap_rst_pid_err", pid_err_o, 0);
    @(posedge clk); #1;
    ready_i = 1'b0;
    send(mk(50, 2'd0, 64'h50, 64'h500));
    send(mk(51, 2'd1, 64'h51, 64'h501));
    for (int r = 0; r < 5; r++) begin
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
      send(mk(52 + r, 2'((2 + r) % 4), 64'h52 + 64'(r), 64'h502 + 64'(r)));
      @(negedge clk);
      chk("wrap_count2", count_o, 2);
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    idle(1);
    reset_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_count0", count_o, 0);
    chk("midrst_valid0", valid_o, 0);
    chk("midrst_ready1", ready_o, 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    send(mk(60, 2'd0, 64'h60, 64'h600));
    idle(3);
    chk("final_drained", sb.size(), 0);
    chk("final_pid_err", pid_err_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
